// File: rtl/prog_mem_loader_if.sv
// Byte-stream input and program-memory write port shared by the loader and its host.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 11,
    parameter int WORD_W = 14
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] pm_addr;
    logic [WORD_W-1:0] pm_data;
    logic              pm_we;

    // master: byte source that also observes the memory writes
    modport master (
        output s_data, s_valid,
        input  s_ready, pm_addr, pm_data, pm_we
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, pm_addr, pm_data, pm_we
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Framed byte-stream loader into program memory; holds the CPU until a frame loads.
// Optional trailing checksum byte and accumulator enabled by defining LOADER_CHECKSUM_EN.
module prog_mem_loader #(
    parameter int ADDR_W    = 11,
    parameter int WORD_W    = 14,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_mem_loader_if.slave  bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_LEN_HI,
        S_LEN_LO,
        S_W_HI,
        S_W_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0]     MAX_N = 16'(MAX_WORDS);
    localparam logic [ADDR_W:0] ONE_W = 1;

    state_t             state_q, state_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic [5:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  pm_addr_q, pm_addr_d;
    logic [WORD_W-1:0]  pm_data_q, pm_data_d;
    logic               pm_we_q, pm_we_d;
    logic [ADDR_W:0]    word_count_q, word_count_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               s_ready;
    logic               accept;
    logic [15:0]        n_word;
    logic [ADDR_W:0]    addr_inc;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            S_HDR, S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO: s_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: s_ready = 1'b1;
`endif
            default: s_ready = 1'b0;
        endcase
    end

    assign accept   = bus.s_valid && s_ready;
    assign n_word   = {len_hi_q, bus.s_data};
    assign addr_inc = {1'b0, addr_q} + ONE_W;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        hi_d         = hi_q;
        addr_d       = addr_q;
        pm_addr_d    = pm_addr_q;
        pm_data_d    = pm_data_q;
        pm_we_d      = 1'b0;
        word_count_d = word_count_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        // start wins over a byte handshake in the same cycle; that byte is dropped
        if (start) begin
            state_d      = S_HDR;
            addr_d       = '0;
            word_count_d = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d       = 8'h00;
`endif
        end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q + bus.s_data;
`endif
            case (state_q)
                S_HDR:    state_d = (bus.s_data == 8'hA5) ? S_LEN_HI : S_ERR;
                S_LEN_HI: begin
                    len_hi_d = bus.s_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (n_word == 16'd0 || n_word > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = n_word[ADDR_W:0];
                        state_d = S_W_HI;
                    end
                end
                S_W_HI: begin
                    if (bus.s_data[7:6] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = bus.s_data[5:0];
                        state_d = S_W_LO;
                    end
                end
                S_W_LO: begin
                    pm_we_d      = 1'b1;
                    pm_addr_d    = addr_q;
                    pm_data_d    = WORD_W'({hi_q, bus.s_data});
                    addr_d       = addr_inc[ADDR_W-1:0];
                    word_count_d = word_count_q + ONE_W;
                    if (addr_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_W_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: state_d = ((csum_q + bus.s_data) == 8'h00) ? S_DONE : S_ERR;
`endif
                default: state_d = state_q;
            endcase
        end

        // status flags are registered copies of the next state's decode
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'h00;
            len_q        <= '0;
            hi_q         <= 6'h00;
            addr_q       <= '0;
            pm_addr_q    <= '0;
            pm_data_q    <= '0;
            pm_we_q      <= 1'b0;
            word_count_q <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            addr_q       <= addr_d;
            pm_addr_q    <= pm_addr_d;
            pm_data_q    <= pm_data_d;
            pm_we_q      <= pm_we_d;
            word_count_q <= word_count_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.pm_addr = pm_addr_q;
    assign bus.pm_data = pm_data_q;
    assign bus.pm_we   = pm_we_q;
    assign cpu_hold    = cpu_hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Randomized self-checking bench for prog_mem_loader against a frame-parsing reference model.
module tb_prog_mem_loader;
    localparam int ADDR_W    = 11;
    localparam int WORD_W    = 14;
    localparam int MAX_WORDS = 2048;
    localparam int WC_W      = ADDR_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    prog_mem_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  frame_q[$];
    logic [24:0] exp_w[$];   // {addr, data}
    logic [24:0] obs_w[$];
    int          exp_consumed;
    bit          exp_done;

    always @(negedge clk) begin
        if (bus.pm_we === 1'b1) obs_w.push_back({bus.pm_addr, bus.pm_data});
    end

    // Reference: parse the frame by its byte-level rules, stopping at the first rejected byte.
    task automatic model_frame();
        int         n;
        int         idx;
        bit         bad;
        logic [7:0] sum;
        logic [7:0] hi;
        exp_w.delete();
        sum = 8'h00;
        bad = 1'b0;
        sum = sum + frame_q[0];
        idx = 1;
        if (frame_q[0] != 8'hA5) begin
            bad = 1'b1;
        end else begin
            n   = {16'd0, frame_q[1], frame_q[2]};
            sum = sum + frame_q[1] + frame_q[2];
            idx = 3;
            if (n == 0 || n > MAX_WORDS) bad = 1'b1;
            for (int i = 0; i < n && !bad; i++) begin
                hi  = frame_q[idx];
                sum = sum + hi;
                idx++;
                if (hi[7:6] != 2'b00) begin
                    bad = 1'b1;
                end else begin
                    sum = sum + frame_q[idx];
                    exp_w.push_back({11'(i), hi[5:0], frame_q[idx]});
                    idx++;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            if (!bad) begin
                sum = sum + frame_q[idx];
                idx++;
                if (sum != 8'h00) bad = 1'b1;
            end
`endif
        end
        exp_consumed = idx;
        exp_done     = !bad;
    endtask

    task automatic append_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        foreach (frame_q[k]) s = s + frame_q[k];
        frame_q.push_back(8'h00 - s);
`endif
    endtask

    task automatic make_frame(input int n);
        logic [13:0] w;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n >> 8));
        frame_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = 14'($urandom);
            frame_q.push_back({2'b00, w[13:8]});
            frame_q.push_back(w[7:0]);
        end
        append_csum();
    endtask

    task automatic make_normal();
        frame_q.delete();
        frame_q = '{8'hA5, 8'h00, 8'h03, 8'h30, 8'h05, 8'h3E, 8'h02, 8'h28, 8'h00};
        append_csum();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a negedge; the byte is taken on the posedge in between.
    task automatic send_byte(input string name, input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL %s_ready_timeout s_ready=%0b after %0d cycles, want 1", name, bus.s_ready, n);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int maxgap, input bit do_start);
        obs_w.delete();
        model_frame();
        if (do_start) begin
            pulse_start();
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1 || word_count !== '0) begin
                miscompares++;
                $display("FAIL %s_armed busy=%0b done=%0b err=%0b hold=%0b wc=%0d, want 1 0 0 1 0",
                         name, busy, done, err, cpu_hold, word_count);
            end
        end
        for (int i = 0; i < exp_consumed; i++) send_byte(name, frame_q[i], int'($urandom_range(0, maxgap)));
        vectors++;
        if (done !== exp_done || err !== !exp_done || cpu_hold !== !exp_done) begin
            miscompares++;
            $display("FAIL %s_status done=%0b err=%0b hold=%0b, want %0b %0b %0b",
                     name, done, err, cpu_hold, exp_done, !exp_done, !exp_done);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.s_ready !== 1'b0 || busy !== 1'b0 || word_count !== WC_W'(exp_w.size())) begin
            miscompares++;
            $display("FAIL %s_final s_ready=%0b busy=%0b wc=%0d, want 0 0 %0d",
                     name, bus.s_ready, busy, word_count, exp_w.size());
        end
        vectors++;
        if (obs_w.size() != exp_w.size()) begin
            miscompares++;
            $display("FAIL %s_write_count got %0d want %0d", name, obs_w.size(), exp_w.size());
        end
        for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
            vectors++;
            if (obs_w[i] !== exp_w[i]) begin
                miscompares++;
                $display("FAIL %s_write%0d addr/data got %h/%h want %h/%h", name, i,
                         obs_w[i][24:14], obs_w[i][13:0], exp_w[i][24:14], exp_w[i][13:0]);
            end
        end
        $display("frame %s: %0d bytes, %0d writes, done=%0b err=%0b", name, exp_consumed, obs_w.size(), done, err);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== '0) begin
            miscompares++;
            $display("FAIL reset_status hold=%0b busy=%0b done=%0b err=%0b wc=%0d, want 1 0 0 0 0",
                     cpu_hold, busy, done, err, word_count);
        end
        vectors++;
        if (bus.s_ready !== 1'b0 || bus.pm_we !== 1'b0 || bus.pm_addr !== '0 || bus.pm_data !== '0) begin
            miscompares++;
            $display("FAIL reset_bus s_ready=%0b we=%0b addr=%h data=%h, want 0 0 0 0",
                     bus.s_ready, bus.pm_we, bus.pm_addr, bus.pm_data);
        end
        $display("reset: hold=%0b busy=%0b wc=%0d", cpu_hold, busy, word_count);
    endtask

    task automatic test_normal();
        logic [24:0] ref_w[3];
        ref_w = '{{11'd0, 14'h3005}, {11'd1, 14'h3E02}, {11'd2, 14'h2800}};
        make_normal();
        run_frame("normal", 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_w.size() <= i || obs_w[i] !== ref_w[i]) begin
                miscompares++;
                $display("FAIL normal_word%0d got %h want %h", i, (obs_w.size() > i) ? obs_w[i] : 25'h0, ref_w[i]);
            end
        end
    endtask

    task automatic test_bad_header();
        frame_q.delete();
        frame_q.push_back(8'h5A);
        run_frame("bad_header", 1, 1'b1);
    endtask

    task automatic test_length_bounds();
        frame_q = '{8'hA5, 8'h00, 8'h00};
        run_frame("len_zero", 1, 1'b1);
        frame_q = '{8'hA5, 8'h08, 8'h01};
        run_frame("len_over", 1, 1'b1);
        make_frame(MAX_WORDS);
        run_frame("len_max", 0, 1'b1);
        vectors++;
        if (obs_w.size() == 0 || obs_w[obs_w.size()-1][24:14] !== 11'h7FF) begin
            miscompares++;
            $display("FAIL len_max_last_addr got %h want 7ff",
                     (obs_w.size() > 0) ? obs_w[obs_w.size()-1][24:14] : 11'h0);
        end
    endtask

    task automatic test_bad_hi();
        make_normal();
        frame_q[5] = 8'h40;
        run_frame("bad_hi", 1, 1'b1);
    endtask

    task automatic test_csum_mismatch();
`ifdef LOADER_CHECKSUM_EN
        make_normal();
        frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] + 8'h01;
        run_frame("csum_bad", 1, 1'b1);
`endif
    endtask

    task automatic test_abort();
        make_frame(5);
        obs_w.delete();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte("abort", frame_q[i], int'($urandom_range(0, 2)));
        @(negedge clk);
        // a header-breaking byte offered together with start must be ignored
        start       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        @(negedge clk);
        start       = 1'b0;
        bus.s_valid = 1'b0;
        vectors++;
        if (word_count !== '0 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1 || bus.s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_rearm wc=%0d busy=%0b done=%0b err=%0b hold=%0b rdy=%0b, want 0 1 0 0 1 1",
                     word_count, busy, done, err, cpu_hold, bus.s_ready);
        end
        vectors++;
        if (obs_w.size() != 2) begin
            miscompares++;
            $display("FAIL abort_partial_writes got %0d want 2", obs_w.size());
        end
        $display("abort: %0d partial writes, wc=%0d after start", obs_w.size(), word_count);
        make_frame(3);
        run_frame("abort_restart", 1, 1'b0);
    endtask

    task automatic test_reset_midword();
        make_frame(2);
        obs_w.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte("rst_mid", frame_q[i], 0);
        bus.s_valid = 1'b1;
        bus.s_data  = frame_q[4];
        reset       = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        vectors++;
        if (bus.pm_we !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0 || word_count !== '0) begin
            miscompares++;
            $display("FAIL reset_midword we=%0b hold=%0b busy=%0b rdy=%0b wc=%0d, want 0 1 0 0 0",
                     bus.pm_we, cpu_hold, busy, bus.s_ready, word_count);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (obs_w.size() != 0) begin
            miscompares++;
            $display("FAIL reset_midword_writes got %0d want 0", obs_w.size());
        end
        $display("reset mid-word: we=%0b hold=%0b writes=%0d", bus.pm_we, cpu_hold, obs_w.size());
    endtask

    task automatic test_random();
        int k;
        for (int f = 0; f < 12; f++) begin
            make_frame(int'($urandom_range(1, 24)));
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(0, frame_q.size() - 1));
                if (k != 1 && k != 2) frame_q[k] = frame_q[k] ^ 8'(1 << $urandom_range(0, 7));
            end
            run_frame($sformatf("rand%0d", f), 3, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            make_frame(int'($urandom_range(1, 16)));
            run_frame($sformatf("b2b%0d", f), 0, 1'b1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_bad_header();
        test_length_bounds();
        test_bad_hi();
        test_csum_mismatch();
        test_abort();
        test_reset_midword();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
